// File: rtl/setting_sweep.sv
`default_nettype none
// ============================================================================
// setting_sweep : emulator run controller. It walks a grid of RX (inner loop)
//                 and TX (outer loop) settings and reports one result per point.
// Revision      : 1.0
// ============================================================================
module setting_sweep #(
   parameter int RX_WIDTH       = 4,
   parameter int TX_WIDTH       = 4,
   parameter int DCO_WIDTH      = 14,
   parameter int ERR_WIDTH      = 32,
   parameter int RX_MIN         = 0,
   parameter int RX_MAX         = 15,
   parameter int TX_MIN         = 0,
   parameter int TX_MAX         = 15,
   parameter int RST_CYCLES     = 200,
   parameter int TIMEOUT_CYCLES = 1 << 20
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 abort,
   input  logic [DCO_WIDTH-1:0] dco_init_in,
   input  logic                 core_done,
   input  logic [ERR_WIDTH-1:0] core_err,
   output logic                 core_rst,
   output logic [RX_WIDTH-1:0]  rx_setting,
   output logic [TX_WIDTH-1:0]  tx_setting,
   output logic [DCO_WIDTH-1:0] dco_init,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [RX_WIDTH-1:0]  res_rx,
   output logic [TX_WIDTH-1:0]  res_tx,
   output logic [ERR_WIDTH-1:0] res_err,
   output logic                 res_timeout,
   output logic                 busy,
   output logic                 sweep_done
);

   localparam int CNT_MAX = (RST_CYCLES > TIMEOUT_CYCLES) ? RST_CYCLES : TIMEOUT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [RX_WIDTH-1:0] RX_LO    = RX_WIDTH'(RX_MIN);
   localparam logic [RX_WIDTH-1:0] RX_HI    = RX_WIDTH'(RX_MAX);
   localparam logic [TX_WIDTH-1:0] TX_LO    = TX_WIDTH'(TX_MIN);
   localparam logic [TX_WIDTH-1:0] TX_HI    = TX_WIDTH'(TX_MAX);
   localparam logic [CNT_W-1:0]    RST_LAST = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0]    TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RESET  = 3'd1,
      S_RUN    = 3'd2,
      S_REPORT = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t               state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic                 core_rst_q;
   logic [RX_WIDTH-1:0]  rx_q;
   logic [TX_WIDTH-1:0]  tx_q;
   logic [DCO_WIDTH-1:0] dco_q;
   logic                 res_valid_q;
   logic [RX_WIDTH-1:0]  res_rx_q;
   logic [TX_WIDTH-1:0]  res_tx_q;
   logic [ERR_WIDTH-1:0] res_err_q;
   logic                 res_timeout_q;
   logic                 busy_q;
   logic                 sweep_done_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         core_rst_q    <= 1'b1;
         rx_q          <= RX_LO;
         tx_q          <= TX_LO;
         dco_q         <= '0;
         res_valid_q   <= 1'b0;
         res_rx_q      <= '0;
         res_tx_q      <= '0;
         res_err_q     <= '0;
         res_timeout_q <= 1'b0;
         busy_q        <= 1'b0;
         sweep_done_q  <= 1'b0;
      end else if (abort && (state_q != S_IDLE)) begin
         // Settings are deliberately left as they were for post-mortem visibility.
         state_q      <= S_IDLE;
         core_rst_q   <= 1'b1;
         res_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
         sweep_done_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               core_rst_q <= 1'b1;
               if (start) begin
                  rx_q         <= RX_LO;
                  tx_q         <= TX_LO;
                  dco_q        <= dco_init_in;
                  cnt_q        <= '0;
                  busy_q       <= 1'b1;
                  sweep_done_q <= 1'b0;
                  state_q      <= S_RESET;
               end
            end
            S_RESET: begin
               if (cnt_q == RST_LAST) begin
                  cnt_q      <= '0;
                  core_rst_q <= 1'b0;
                  state_q    <= S_RUN;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_RUN: begin
               // A done arriving on the expiry cycle still counts as a clean finish.
               if (core_done || (cnt_q == TO_LAST)) begin
                  res_valid_q   <= 1'b1;
                  res_rx_q      <= rx_q;
                  res_tx_q      <= tx_q;
                  res_err_q     <= core_err;
                  res_timeout_q <= ~core_done;
                  core_rst_q    <= 1'b1;
                  state_q       <= S_REPORT;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_REPORT: begin
               if (res_valid_q && res_ready) begin
                  res_valid_q <= 1'b0;
                  cnt_q       <= '0;
                  if (rx_q != RX_HI) begin
                     rx_q    <= rx_q + RX_WIDTH'(1);
                     state_q <= S_RESET;
                  end else if (tx_q != TX_HI) begin
                     rx_q    <= RX_LO;
                     tx_q    <= tx_q + TX_WIDTH'(1);
                     state_q <= S_RESET;
                  end else begin
                     busy_q       <= 1'b0;
                     sweep_done_q <= 1'b1;
                     state_q      <= S_DONE;
                  end
               end
            end
            default: begin
               core_rst_q <= 1'b1;
               busy_q     <= 1'b0;
               state_q    <= S_IDLE;
            end
         endcase
      end
   end

   assign core_rst    = core_rst_q;
   assign rx_setting  = rx_q;
   assign tx_setting  = tx_q;
   assign dco_init    = dco_q;
   assign res_valid   = res_valid_q;
   assign res_rx      = res_rx_q;
   assign res_tx      = res_tx_q;
   assign res_err     = res_err_q;
   assign res_timeout = res_timeout_q;
   assign busy        = busy_q;
   assign sweep_done  = sweep_done_q;

endmodule
`default_nettype wire

// File: tb/tb_setting_sweep.sv
`default_nettype none
// ============================================================================
// tb_setting_sweep : directed bench for setting_sweep on a 3x2 grid.
// Revision         : 1.0
// ============================================================================
module tb_setting_sweep;

   localparam int RXW = 4;
   localparam int TXW = 4;
   localparam int DW  = 14;
   localparam int EW  = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [DW-1:0] dco_init_in = '0;
   logic          core_done = 1'b0;
   logic [EW-1:0] core_err = '0;
   logic          res_ready = 1'b1;

   logic           core_rst;
   logic [RXW-1:0] rx_setting;
   logic [TXW-1:0] tx_setting;
   logic [DW-1:0]  dco_init;
   logic           res_valid;
   logic [RXW-1:0] res_rx;
   logic [TXW-1:0] res_tx;
   logic [EW-1:0]  res_err;
   logic           res_timeout;
   logic           busy;
   logic           sweep_done;

   int n_chk  = 0;
   int n_fail = 0;

   setting_sweep #(
      .RX_WIDTH(RXW), .TX_WIDTH(TXW), .DCO_WIDTH(DW), .ERR_WIDTH(EW),
      .RX_MIN(0), .RX_MAX(2), .TX_MIN(9), .TX_MAX(10),
      .RST_CYCLES(200), .TIMEOUT_CYCLES(64)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .dco_init_in(dco_init_in), .core_done(core_done), .core_err(core_err),
      .core_rst(core_rst), .rx_setting(rx_setting), .tx_setting(tx_setting),
      .dco_init(dco_init), .res_valid(res_valid), .res_ready(res_ready),
      .res_rx(res_rx), .res_tx(res_tx), .res_err(res_err),
      .res_timeout(res_timeout), .busy(busy), .sweep_done(sweep_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Leaves the bench on the negedge of the first RUN cycle.
   task automatic wait_run();
      int n = 0;
      while (core_rst === 1'b1 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("run_entry", 64'(core_rst), 64'd0);
   endtask

   // mode 0: done after 5 cycles, 1: ready held low 30 cycles, 2: timeout, 3: done on expiry
   task automatic run_point(input int rx, input int tx, input int mode);
      logic [EW-1:0] err;
      int            n;
      logic          last;
      err       = EW'(rx + 16 * tx);
      last      = (rx == 2) && (tx == 10);
      core_err  = err;
      res_ready = (mode != 1);
      wait_run();
      check("rx_setting", 64'(rx_setting), 64'(rx));
      check("tx_setting", 64'(tx_setting), 64'(tx));
      case (mode)
         2: begin
            n = 0;
            while (res_valid !== 1'b1 && n < 200) begin
               @(negedge clk);
               n++;
            end
            check("timeout_latency", 64'(n), 64'd64);
         end
         3: begin
            repeat (63) @(negedge clk);
            check("no_early_valid", 64'(res_valid), 64'd0);
            core_done = 1'b1;
            @(negedge clk);
            core_done = 1'b0;
         end
         default: begin
            repeat (4) @(negedge clk);
            core_done = 1'b1;
            @(negedge clk);
            core_done = 1'b0;
         end
      endcase
      check("res_valid", 64'(res_valid), 64'd1);
      check("res_rx", 64'(res_rx), 64'(rx));
      check("res_tx", 64'(res_tx), 64'(tx));
      check("res_err", 64'(res_err), 64'(err));
      check("res_timeout", 64'(res_timeout), (mode == 2) ? 64'd1 : 64'd0);
      check("core_rst_report", 64'(core_rst), 64'd1);
      if (mode == 1) begin
         for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check("hold_valid", 64'(res_valid), 64'd1);
            check("hold_err", 64'(res_err), 64'(err));
            check("hold_rx", 64'(res_rx), 64'(rx));
            check("hold_setting", 64'(rx_setting), 64'(rx));
         end
         res_ready = 1'b1;
      end
      @(negedge clk);
      check("valid_after_hs", 64'(res_valid), 64'd0);
      check("core_rst_after_hs", 64'(core_rst), 64'd1);
      check("busy_after_hs", 64'(busy), last ? 64'd0 : 64'd1);
      check("done_after_hs", 64'(sweep_done), last ? 64'd1 : 64'd0);
      if (!last)
         check("next_rx", 64'(rx_setting), (rx == 2) ? 64'd0 : 64'(rx + 1));
   endtask

   initial begin
      int h;
      repeat (3) @(negedge clk);
      check("rst_core_rst", 64'(core_rst), 64'd1);
      check("rst_rx", 64'(rx_setting), 64'd0);
      check("rst_tx", 64'(tx_setting), 64'd9);
      check("rst_dco", 64'(dco_init), 64'd0);
      check("rst_valid", 64'(res_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(sweep_done), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_busy", 64'(busy), 64'd0);

      // Full sweep with timing, stall, timeout and race points mixed in.
      dco_init_in = 14'h1A5;
      start       = 1'b1;
      @(negedge clk);
      start       = 1'b0;
      dco_init_in = '0;
      check("start_busy", 64'(busy), 64'd1);
      check("dco_latched", 64'(dco_init), 64'h1A5);
      h = 0;
      while (core_rst === 1'b1 && h < 400) begin
         h++;
         @(negedge clk);
      end
      check("core_rst_hold", 64'(h), 64'd200);
      run_point(0, 9, 0);
      run_point(1, 9, 1);
      run_point(2, 9, 2);
      run_point(0, 10, 3);
      run_point(1, 10, 0);
      run_point(2, 10, 0);
      repeat (3) @(negedge clk);
      check("done_hold", 64'(sweep_done), 64'd1);
      check("done_core_rst", 64'(core_rst), 64'd1);
      check("done_dco", 64'(dco_init), 64'h1A5);

      // Abort during the RUN phase of the second point.
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("restart_rx", 64'(rx_setting), 64'd0);
      run_point(0, 9, 0);
      wait_run();
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_core_rst", 64'(core_rst), 64'd1);
      check("abort_valid", 64'(res_valid), 64'd0);
      check("abort_done", 64'(sweep_done), 64'd0);
      check("abort_rx_kept", 64'(rx_setting), 64'd1);
      @(negedge clk);
      check("abort_idle", 64'(busy), 64'd0);

      // Restart, then asynchronous reset while a result is pending.
      dco_init_in = 14'h2BC;
      start       = 1'b1;
      @(negedge clk);
      start       = 1'b0;
      check("restart2_rx", 64'(rx_setting), 64'd0);
      check("restart2_tx", 64'(tx_setting), 64'd9);
      check("restart2_dco", 64'(dco_init), 64'h2BC);
      res_ready = 1'b0;
      core_err  = 32'h99;
      wait_run();
      repeat (2) @(negedge clk);
      core_done = 1'b1;
      @(negedge clk);
      core_done = 1'b0;
      check("pre_rst_valid", 64'(res_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", 64'(res_valid), 64'd0);
      check("arst_core_rst", 64'(core_rst), 64'd1);
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_err", 64'(res_err), 64'd0);
      check("arst_dco", 64'(dco_init), 64'd0);
      @(negedge clk);
      rst_n     = 1'b1;
      res_ready = 1'b1;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("post_rst_busy", 64'(busy), 64'd1);
      run_point(0, 9, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
